// File: rtl/encoder_scan_sequencer.sv
// Periodic snapshot strobe plus a bus-arbitrated scan of every encoder's count register,
// published to the host as a coherent double-buffered frame with a valid/ack handshake.
module encoder_scan_sequencer #(
    parameter int NUM_ENC = 4,
    parameter int PERIOD  = 120000,
    parameter int SETTLE  = 2
) (
    input  logic               clk_12MHz,
    input  logic               reset,
    input  logic               enable,
    output logic               period_tick,
    output logic               bus_req,
    input  logic               bus_grant,
    output logic [NUM_ENC-1:0] enc_select,
    output logic [7:0]         register_addr,
    output logic               rw,
    input  logic [31:0]        databus,
    input  logic [2:0]         reg_size,
    input  logic [2:0]         rd_index,
    output logic [31:0]        rd_data,
    output logic [NUM_ENC-1:0] rd_err,
    output logic               frame_valid,
    input  logic               frame_ack,
    output logic [15:0]        frame_count,
    output logic               overrun
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_SEL, S_GAP, S_SWAP} state_e;

    localparam int             DW       = $clog2(PERIOD);
    localparam int             SW       = $clog2(SETTLE + 1);
    localparam logic [DW-1:0]  DIV_LAST = DW'(PERIOD - 1);
    localparam logic [SW-1:0]  SET_LAST = SW'(SETTLE);
    localparam logic [2:0]     LAST_CH  = 3'(NUM_ENC - 1);

    state_e             state_q;
    logic [DW-1:0]      div_q;
    logic               tick_pending_q;
    logic [2:0]         ch_q;
    logic [SW-1:0]      settle_q;
    logic [31:0]        shadow_q [NUM_ENC];
    logic [NUM_ENC-1:0] err_q;
    logic [31:0]        front_q  [NUM_ENC];
    logic [NUM_ENC-1:0] rd_err_q;
    logic               period_tick_q;
    logic               frame_valid_q;
    logic               overrun_q;
    logic [15:0]        frame_count_q;

    logic wrap_d;
    logic defer_d;
    logic swap_over_d;

    assign wrap_d      = enable && (div_q == DIV_LAST);
    assign defer_d     = wrap_d && (state_q != S_IDLE);
    assign swap_over_d = (state_q == S_SWAP) && frame_valid_q;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else if (!enable || wrap_d) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + DW'(1);
        end
    end

    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            ch_q           <= '0;
            settle_q       <= '0;
            tick_pending_q <= 1'b0;
            period_tick_q  <= 1'b0;
            frame_valid_q  <= 1'b0;
            overrun_q      <= 1'b0;
            frame_count_q  <= '0;
            err_q          <= '0;
            rd_err_q       <= '0;
            // NOTE: the banks are a handful of flops, not RAM, so clearing them on reset is cheap and wanted.
            for (int i = 0; i < NUM_ENC; i++) begin
                shadow_q[i] <= '0;
                front_q[i]  <= '0;
            end
        end else begin
            period_tick_q <= 1'b0;

            if (!enable) begin
                tick_pending_q <= 1'b0;
            end else if (defer_d) begin
                tick_pending_q <= 1'b1;
            end

            if (defer_d || swap_over_d) begin
                overrun_q <= 1'b1;
            end else if (frame_ack) begin
                overrun_q <= 1'b0;
            end

            // A publish wins over a same-cycle ack.
            if (state_q == S_SWAP) begin
                frame_valid_q <= 1'b1;
            end else if (frame_ack) begin
                frame_valid_q <= 1'b0;
            end

            case (state_q)
                S_IDLE: begin
                    if (enable && (tick_pending_q || wrap_d)) begin
                        period_tick_q  <= 1'b1;
                        tick_pending_q <= 1'b0;
                        ch_q           <= '0;
                        state_q        <= S_REQ;
                    end
                end
                S_REQ: begin
                    settle_q <= '0;
                    if (bus_grant) begin
                        state_q <= S_SEL;
                    end
                end
                S_SEL: begin
                    if (!bus_grant) begin
                        state_q <= S_REQ;
                    end else if (settle_q == SET_LAST) begin
                        for (int i = 0; i < NUM_ENC; i++) begin
                            if (ch_q == 3'(i)) begin
                                shadow_q[i] <= (reg_size == 3'd4) ? databus : 32'd0;
                                err_q[i]    <= (reg_size != 3'd4);
                            end
                        end
                        state_q <= S_GAP;
                    end else begin
                        settle_q <= settle_q + SW'(1);
                    end
                end
                S_GAP: begin
                    settle_q <= '0;
                    if (ch_q == LAST_CH) begin
                        state_q <= S_SWAP;
                    end else begin
                        ch_q    <= ch_q + 3'd1;
                        state_q <= bus_grant ? S_SEL : S_REQ;
                    end
                end
                S_SWAP: begin
                    for (int i = 0; i < NUM_ENC; i++) begin
                        front_q[i] <= shadow_q[i];
                    end
                    rd_err_q      <= err_q;
                    frame_count_q <= frame_count_q + 16'd1;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Selects are gated by grant so a lost bus releases the peripheral in the same cycle.
    always_comb begin
        enc_select = '0;
        for (int i = 0; i < NUM_ENC; i++) begin
            enc_select[i] = (state_q == S_SEL) && bus_grant && (ch_q == 3'(i));
        end
    end

    always_comb begin
        rd_data = 32'd0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (rd_index == 3'(i)) begin
                rd_data = front_q[i];
            end
        end
    end

    assign rw            = |enc_select;
    assign register_addr = rw ? 8'd1 : 8'd0;
    assign bus_req       = (state_q == S_REQ) || (state_q == S_SEL) || (state_q == S_GAP);
    assign period_tick   = period_tick_q;
    assign frame_valid   = frame_valid_q;
    assign overrun       = overrun_q;
    assign frame_count   = frame_count_q;
    assign rd_err        = rd_err_q;

endmodule

// File: tb/tb_encoder_scan_sequencer.sv
// Directed bench for encoder_scan_sequencer: encoder models that only drive valid data
// once their select has settled, plus hand-computed timing and frame contents.
module tb_encoder_scan_sequencer;

    localparam int NUM_ENC = 4;
    localparam int PERIOD  = 64;
    localparam int SETTLE  = 2;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               period_tick;
    logic               bus_req;
    logic               bus_grant;
    logic [NUM_ENC-1:0] enc_select;
    logic [7:0]         register_addr;
    logic               rw;
    logic [31:0]        databus;
    logic [2:0]         reg_size;
    logic [2:0]         rd_index;
    logic [31:0]        rd_data;
    logic [NUM_ENC-1:0] rd_err;
    logic               frame_valid;
    logic               frame_ack;
    logic [15:0]        frame_count;
    logic               overrun;

    always #5 clk = ~clk;

    encoder_scan_sequencer #(.NUM_ENC(NUM_ENC), .PERIOD(PERIOD), .SETTLE(SETTLE)) dut (
        .clk_12MHz(clk), .reset(reset), .enable(enable), .period_tick(period_tick),
        .bus_req(bus_req), .bus_grant(bus_grant), .enc_select(enc_select),
        .register_addr(register_addr), .rw(rw), .databus(databus), .reg_size(reg_size),
        .rd_index(rd_index), .rd_data(rd_data), .rd_err(rd_err), .frame_valid(frame_valid),
        .frame_ack(frame_ack), .frame_count(frame_count), .overrun(overrun)
    );

    int               n_cmp = 0;
    int               n_err = 0;
    int               cyc = 0;
    logic [31:0]      cnt_m  [NUM_ENC];
    logic [2:0]       size_m [NUM_ENC];
    int               age    [NUM_ENC];
    int               rises  [NUM_ENC];
    logic [NUM_ENC-1:0] prev_sel = '0;

    // Encoder models: garbage until the select has been high for SETTLE edges.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_sel <= enc_select;
        for (int i = 0; i < NUM_ENC; i++) begin
            age[i] <= enc_select[i] ? age[i] + 1 : 0;
            if (enc_select[i] && !prev_sel[i]) rises[i] <= rises[i] + 1;
        end
    end

    always_comb begin
        databus  = 32'hDEADBEEF;
        reg_size = 3'd0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (enc_select[i] && age[i] >= SETTLE) begin
                databus  = cnt_m[i];
                reg_size = size_m[i];
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_tick(input string tag, input int budget);
        int n = 0;
        while (period_tick !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(period_tick), 32'd1);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int n = 0;
        while (frame_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(frame_valid), 32'd1);
    endtask

    task automatic go_to(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic set_counts(input logic [31:0] c0, c1, c2, c3);
        cnt_m[0] = c0; cnt_m[1] = c1; cnt_m[2] = c2; cnt_m[3] = c3;
    endtask

    task automatic read_frame(input string tag, input logic [31:0] e0, e1, e2, e3);
        logic [31:0] exp_w [4];
        exp_w = '{e0, e1, e2, e3};
        for (int i = 0; i < 4; i++) begin
            rd_index = 3'(i);
            #1;
            check($sformatf("%s_rd%0d", tag, i), rd_data, exp_w[i]);
        end
        @(negedge clk);
    endtask

    task automatic ack(input string tag);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        check(tag, 32'(frame_valid), 32'd0);
    endtask

    int rel, t0, t1, t2, t3, t4, t5, t6, t7, t8, t9, t_def, bad, n_ticks;
    int r_base [NUM_ENC];

    initial begin
        reset = 1'b0; enable = 1'b0; bus_grant = 1'b1; frame_ack = 1'b0; rd_index = 3'd0;
        set_counts(32'd5, 32'hFFFFFFFD, 32'd0, 32'd1000);
        for (int i = 0; i < NUM_ENC; i++) begin
            size_m[i] = 3'd4; age[i] = 0; rises[i] = 0;
        end
        repeat (3) @(negedge clk);

        check("rst_tick", 32'(period_tick), 32'd0);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_select", 32'(enc_select), 32'd0);
        check("rst_rw_addr", {23'd0, rw, register_addr}, 32'd0);
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_count", 32'(frame_count), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rd", rd_data, 32'd0);
        check("rst_rd_err", 32'(rd_err), 32'd0);

        // Basic scan, grant tied high.
        reset = 1'b1; enable = 1'b1; rel = cyc;
        wait_tick("t1_tick_seen", 200);
        check("t1_first_tick_delay", 32'(cyc - rel), 32'd64);
        t0 = cyc;
        check("t1_req_with_tick", 32'(bus_req), 32'd1);
        @(negedge clk);
        check("t1_tick_width", 32'(period_tick), 32'd0);
        go_to(t0 + 1);
        check("t1_sel_ch0", {22'd0, rw, register_addr, 1'b0, enc_select}, {22'd0, 1'b1, 8'd1, 1'b0, 4'b0001});
        wait_valid("t1_valid_seen", 100);
        check("t1_latency", 32'(cyc - t0), 32'd18);
        check("t1_count", 32'(frame_count), 32'd1);
        check("t1_rd_err", 32'(rd_err), 32'd0);
        check("t1_bus_released", 32'(bus_req), 32'd0);
        read_frame("t1", 32'd5, 32'hFFFFFFFD, 32'd0, 32'd1000);
        rd_index = 3'd4; #1; check("t1_rd_idx4", rd_data, 32'd0);
        rd_index = 3'd7; #1; check("t1_rd_idx7", rd_data, 32'd0);
        @(negedge clk);
        ack("t1_ack");

        // Grant withheld for 10 cycles.
        set_counts(32'h12345678, 32'd7, 32'h80000000, 32'hFFFFFFFF);
        bus_grant = 1'b0;
        wait_tick("t2_tick_seen", 200);
        check("t2_period", 32'(cyc - t0), 32'd64);
        t1 = cyc; bad = 0;
        repeat (10) begin
            if (enc_select !== '0 || rw !== 1'b0) bad++;
            @(negedge clk);
        end
        check("t2_no_sel_while_waiting", 32'(bad), 32'd0);
        check("t2_req_held", 32'(bus_req), 32'd1);
        bus_grant = 1'b1;
        wait_valid("t2_valid_seen", 100);
        check("t2_latency", 32'(cyc - t1), 32'd28);
        check("t2_count", 32'(frame_count), 32'd2);
        read_frame("t2", 32'h12345678, 32'd7, 32'h80000000, 32'hFFFFFFFF);
        ack("t2_ack");

        // Grant dropped for 3 cycles during ch2 select.
        set_counts(32'd100, 32'd200, 32'd300, 32'd400);
        wait_tick("t3_tick_seen", 200);
        check("t3_period", 32'(cyc - t1), 32'd64);
        t2 = cyc;
        for (int i = 0; i < NUM_ENC; i++) r_base[i] = rises[i];
        go_to(t2 + 10);
        check("t3_sel_ch2", 32'(enc_select), 32'd4);
        bus_grant = 1'b0;
        #1;
        check("t3_sel_drop_immediate", 32'(enc_select), 32'd0);
        check("t3_rw_drop", 32'(rw), 32'd0);
        repeat (3) @(negedge clk);
        bus_grant = 1'b1;
        wait_valid("t3_valid_seen", 100);
        check("t3_latency", 32'(cyc - t2), 32'd23);
        check("t3_rises_ch0", 32'(rises[0] - r_base[0]), 32'd1);
        check("t3_rises_ch1", 32'(rises[1] - r_base[1]), 32'd1);
        check("t3_rises_ch2", 32'(rises[2] - r_base[2]), 32'd2);
        check("t3_rises_ch3", 32'(rises[3] - r_base[3]), 32'd1);
        check("t3_count", 32'(frame_count), 32'd3);
        read_frame("t3", 32'd100, 32'd200, 32'd300, 32'd400);
        ack("t3_ack");

        // Size error on ch1.
        set_counts(32'd11, 32'd22, 32'd33, 32'd44);
        size_m[1] = 3'd1;
        wait_tick("t4_tick_seen", 200);
        check("t4_period", 32'(cyc - t2), 32'd64);
        t3 = cyc;
        wait_valid("t4_valid_seen", 100);
        check("t4_latency", 32'(cyc - t3), 32'd18);
        check("t4_rd_err", 32'(rd_err), 32'b0010);
        check("t4_count", 32'(frame_count), 32'd4);
        check("t4_no_overrun", 32'(overrun), 32'd0);
        read_frame("t4", 32'd11, 32'd0, 32'd33, 32'd44);
        ack("t4_ack");
        size_m[1] = 3'd4;

        // Unread frame overwritten.
        set_counts(32'd1, 32'd2, 32'd3, 32'd4);
        wait_tick("t5_tick_seen", 200);
        t4 = cyc;
        wait_valid("t5_valid_seen", 100);
        check("t5_count_first", 32'(frame_count), 32'd5);
        set_counts(32'd9, 32'd8, 32'd7, 32'd6);
        @(negedge clk);
        wait_tick("t5_tick2_seen", 200);
        t5 = cyc;
        check("t5_period", 32'(t5 - t4), 32'd64);
        go_to(t5 + 17);
        check("t5_overrun_before_swap", 32'(overrun), 32'd0);
        check("t5_count_before_swap", 32'(frame_count), 32'd5);
        go_to(t5 + 18);
        check("t5_valid_kept", 32'(frame_valid), 32'd1);
        check("t5_overrun_set", 32'(overrun), 32'd1);
        check("t5_count_second", 32'(frame_count), 32'd6);
        read_frame("t5", 32'd9, 32'd8, 32'd7, 32'd6);
        ack("t5_ack");
        check("t5_overrun_cleared", 32'(overrun), 32'd0);

        // Tick deferred while the scan is stalled on grant.
        set_counts(32'd1, 32'd2, 32'd3, 32'd4);
        bus_grant = 1'b0;
        wait_tick("t6_tick_seen", 200);
        t6 = cyc;
        check("t6_period", 32'(t6 - t5), 32'd64);
        go_to(t6 + 64);
        check("t6_defer_overrun", 32'(overrun), 32'd1);
        check("t6_defer_no_tick", 32'(period_tick), 32'd0);
        check("t6_still_requesting", 32'(bus_req), 32'd1);
        bus_grant = 1'b1;
        wait_valid("t6_valid_seen", 100);
        check("t6_latency", 32'(cyc - t6), 32'd82);
        check("t6_overrun_held", 32'(overrun), 32'd1);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        t_def = cyc;
        check("t6_deferred_tick", 32'(period_tick), 32'd1);
        check("t6_deferred_tick_time", 32'(t_def - t6), 32'd83);
        check("t6_ack_valid", 32'(frame_valid), 32'd0);
        check("t6_ack_overrun", 32'(overrun), 32'd0);
        @(negedge clk);
        check("t6_deferred_tick_width", 32'(period_tick), 32'd0);
        wait_valid("t6_valid2_seen", 100);
        check("t6_latency2", 32'(cyc - t_def), 32'd18);
        ack("t6_ack2");
        wait_tick("t6_next_tick_seen", 200);
        t7 = cyc;
        check("t6_not_doubled", 32'(t7 - t6), 32'd128);

        // Asynchronous reset in the middle of a select.
        go_to(t7 + 2);
        check("t7_sel_before_reset", 32'(enc_select), 32'd1);
        reset = 1'b0;
        #1;
        check("t7_rst_select", 32'(enc_select), 32'd0);
        check("t7_rst_bus_req", 32'(bus_req), 32'd0);
        check("t7_rst_rw", 32'(rw), 32'd0);
        check("t7_rst_count", 32'(frame_count), 32'd0);
        check("t7_rst_rd", rd_data, 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1; rel = cyc;
        wait_tick("t7_tick_seen", 200);
        t8 = cyc;
        check("t7_first_tick_delay", 32'(t8 - rel), 32'd64);
        wait_valid("t7_valid_seen", 100);
        check("t7_latency", 32'(cyc - t8), 32'd18);
        check("t7_count_restart", 32'(frame_count), 32'd1);
        read_frame("t7", 32'd1, 32'd2, 32'd3, 32'd4);
        ack("t7_ack");

        // Enable falls mid-scan.
        set_counts(32'd21, 32'd22, 32'd23, 32'd24);
        wait_tick("t8_tick_seen", 200);
        t9 = cyc;
        check("t8_period", 32'(t9 - t8), 32'd64);
        go_to(t9 + 3);
        enable = 1'b0;
        wait_valid("t8_valid_seen", 100);
        check("t8_latency", 32'(cyc - t9), 32'd18);
        check("t8_count", 32'(frame_count), 32'd2);
        read_frame("t8", 32'd21, 32'd22, 32'd23, 32'd24);
        ack("t8_ack");
        n_ticks = 0;
        repeat (150) begin
            @(negedge clk);
            if (period_tick === 1'b1) n_ticks++;
        end
        check("t8_no_ticks_disabled", 32'(n_ticks), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/encoder_scan_sequencer.md
Name: encoder_scan_sequencer

Overview:
- Sequences the encoder peripherals that share the 32-bit read databus.
- Generates the periodic snapshot strobe that latches every encoder's count.
- After each strobe, reads register 1 of each encoder over the shared bus into a shadow bank, then publishes a coherent frame to the host side with a valid/ack handshake.
- Replaces the free-running 100 Hz snapshot and per-encoder host polling.

Parameters:
NUM_ENC, 4, number of encoder peripherals scanned (2..8)
PERIOD, 120000, clk_12MHz cycles between snapshot strobes (100 Hz)
SETTLE, 2, cycles after select rising edge before databus is sampled (min 2)

Ports:
clk_12MHz  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low; all state cleared while low
enable  input  1  1 = run divider and scans
period_tick  output  1  one-cycle snapshot strobe to every encoder's count reset/latch
bus_req  output  1  request for shared databus
bus_grant  input  1  bus owned by sequencer while high
enc_select  output  NUM_ENC  one-hot select to encoder peripherals
register_addr  output  8  constant 8'd1 while scanning, 0 otherwise
rw  output  1  1 whenever any enc_select bit is high, else 0
databus  input  32  shared read data
reg_size  input  3  reply size from selected peripheral
rd_index  input  3  host frame read index (values >= NUM_ENC return 0)
rd_data  output  32  front-bank word[rd_index], combinational
rd_err  output  NUM_ENC  per-channel size-error mask of front frame
frame_valid  output  1  new frame available
frame_ack  input  1  host consumed frame
frame_count  output  16  frames published, wraps 16'hFFFF -> 0
overrun  output  1  sticky: tick deferred or unread frame overwritten

Behaviour:
- Reset (low): all outputs 0; divider, banks, masks, frame_count, and FSM (IDLE) cleared.
- Divider: counts 0..PERIOD-1 while enable=1; held at 0 while enable=0. The wrap cycle raises tick_pending.
- Tick issue:
  - period_tick pulses for exactly one cycle when tick_pending=1 and FSM is IDLE; tick_pending clears the same cycle.
  - If tick_pending rises while FSM is not IDLE, the tick is deferred (not dropped, not doubled) and overrun is set.
- FSM:
  - IDLE: after period_tick, go to REQ the next cycle; ch=0.
  - REQ: bus_req=1; on bus_grant=1 go to SEL.
  - SEL: enc_select[ch]=1, register_addr=1, rw=1. Held SETTLE+1 cycles; databus and reg_size are captured on the last of those cycles (CAP).
    - reg_size==4: shadow[ch]=databus, err[ch]=0.
    - Otherwise: shadow[ch]=0, err[ch]=1.
  - GAP: one cycle with all selects low so the next select produces a fresh rising edge. Then ch+1 goes to SEL, or after ch==NUM_ENC-1 go to SWAP.
  - SWAP (one cycle): front bank<=shadow, rd_err<=err, frame_count+=1, frame_valid<=1, bus_req<=0. Then IDLE.
- bus_req stays 1 from REQ through GAP of the last channel.
- Grant loss: bus_grant falling in SEL/GAP drops enc_select the same cycle (combinational gate) and the FSM returns to REQ. The current channel restarts from the start of SEL; completed channels are kept.
- Handshake:
  - frame_ack with frame_valid=1 clears frame_valid next cycle; frame_ack with frame_valid=0 is ignored.
  - SWAP while frame_valid=1 sets overrun. SWAP has priority over a same-cycle ack, so frame_valid stays 1.
  - overrun clears on a frame_ack cycle that does not coincide with a new overrun event.
- enable falling mid-scan: the scan completes and publishes; no further ticks.
- Scan latency: tick to frame_valid = 1 + grant wait + NUM_ENC*(SETTLE+2) + 1 cycles. Scan must finish inside PERIOD.

Test Plan:
1. PERIOD=64, NUM_ENC=4, grant tied 1, encoder models return counts 5,-3,0,1000 with size 4 -> period_tick every 64 cycles; frame_valid 1+4*4+1=18 cycles after tick; rd_data idx0..3 = 32'd5, 32'hFFFFFFFD, 0, 32'd1000; rd_err=0; frame_count=1.
2. Grant withheld 10 cycles after bus_req -> no enc_select during wait; frame published 10 cycles later; data correct.
3. Grant dropped in SEL of ch2 for 3 cycles -> enc_select[2] low immediately; ch2 reselected with a fresh rising edge; ch0/ch1 not re-read; final data correct.
4. Model ch1 returns reg_size=1 -> rd_data[1]=0, rd_err=4'b0010, other channels valid.
5. No frame_ack across two periods -> second SWAP sets overrun, frame_count=2, frame_valid stays 1; ack -> frame_valid and overrun clear next cycle.
6. Assert reset low mid-SEL, then release -> outputs 0 immediately (async), enc_select low; first tick occurs PERIOD cycles after release; frame_count restarts from 0 -> 1.
